// File: rtl/level_pkg.sv
// Shared state encoding and constants for the level trap sequencer.
package level_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    OPENING = 3'd2,
    FINISH  = 3'd3,
    DEAD    = 3'd4,
    DONE    = 3'd5
  } level_state_e;

  localparam int DEATH_CNT_W = 8;

endpackage

// File: rtl/trap_anim_ctr.sv
// Trap animation offset: steps by STEP per tick, saturating at OPEN_DIST.
module trap_anim_ctr #(
  parameter int OFS_WIDTH = 6,
  parameter int STEP      = 2,
  parameter int OPEN_DIST = 32
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 tick,
  output logic [OFS_WIDTH-1:0] offset,
  output logic                 at_max
);

  localparam logic [OFS_WIDTH:0] STEP_W = (OFS_WIDTH+1)'(STEP);
  localparam logic [OFS_WIDTH:0] MAX_W  = (OFS_WIDTH+1)'(OPEN_DIST);

  logic [OFS_WIDTH-1:0] offset_q, offset_d;
  logic [OFS_WIDTH:0]   sum, sat;

  // at_max flags the tick on which the offset lands on OPEN_DIST.
  always_comb begin
    sum      = {1'b0, offset_q} + STEP_W;
    sat      = (sum > MAX_W) ? MAX_W : sum;
    at_max   = en && tick && (sat == MAX_W);
    offset_d = offset_q;
    if (clear)            offset_d = '0;
    else if (en && tick)  offset_d = sat[OFS_WIDTH-1:0];
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) offset_q <= '0;
    else       offset_q <= offset_d;
  end

  assign offset = offset_q;

endmodule

// File: rtl/level_trap_seq.sv
// Level sequencer: opens traps in order as the player passes triggers.
// Optional death_count output enabled by LEVEL_DEATH_COUNT_EN.
module level_trap_seq
  import level_pkg::*;
#(
  parameter int NUM_TRAPS     = 3,
  parameter int X_WIDTH       = 10,
  parameter int OFS_WIDTH     = 6,
  parameter int STEP          = 2,
  parameter int OPEN_DIST     = 32,
  parameter int RESPAWN_TICKS = 30
) (
  input  logic                           Clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           start,
  input  logic                           death,
  input  logic [X_WIDTH-1:0]             x_pos,
  input  logic [NUM_TRAPS*X_WIDTH-1:0]   trig_x,
  input  logic [X_WIDTH-1:0]             finish_x,
  output logic [2:0]                     state,
  output logic [2:0]                     trap_idx,
  output logic [NUM_TRAPS-1:0]           trap_opening,
  output logic [NUM_TRAPS-1:0]           trap_open,
  output logic [OFS_WIDTH-1:0]           trap_offset,
  output logic                           done,
  output logic                           respawn
`ifdef LEVEL_DEATH_COUNT_EN
  ,
  output logic [DEATH_CNT_W-1:0]         death_count
`endif
);

  localparam int            CNT_W    = $clog2(RESPAWN_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_TICKS - 1);

  level_state_e         state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [NUM_TRAPS-1:0] open_q, open_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 resp_q, resp_d;
  logic [X_WIDTH-1:0]   trig_sel;
  logic                 live, anim_clr, anim_max;

  trap_anim_ctr #(
    .OFS_WIDTH (OFS_WIDTH),
    .STEP      (STEP),
    .OPEN_DIST (OPEN_DIST)
  ) u_anim (
    .Clk    (Clk),
    .reset  (reset),
    .clear  (anim_clr),
    .en     (state_q == OPENING),
    .tick   (tick),
    .offset (trap_offset),
    .at_max (anim_max)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    open_d   = open_q;
    cnt_d    = cnt_q;
    resp_d   = 1'b0;
    anim_clr = 1'b0;
    trig_sel = '0;
    for (int i = 0; i < NUM_TRAPS; i++)
      if (idx_q == 3'(i)) trig_sel = trig_x[i*X_WIDTH +: X_WIDTH];
    live = (state_q == ARMED) || (state_q == OPENING) || (state_q == FINISH);

    // Death outranks every other event while the player is in play.
    if (live && death) begin
      state_d  = DEAD;
      idx_d    = '0;
      open_d   = '0;
      cnt_d    = '0;
      anim_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_d  = ARMED;
          idx_d    = '0;
          open_d   = '0;
          anim_clr = 1'b1;
        end
        ARMED: if (x_pos > trig_sel) begin
          state_d  = OPENING;
          anim_clr = 1'b1;
        end
        OPENING: if (anim_max) begin
          for (int i = 0; i < NUM_TRAPS; i++)
            if (idx_q == 3'(i)) open_d[i] = 1'b1;
          if (idx_q == 3'(NUM_TRAPS - 1)) state_d = FINISH;
          else begin
            state_d = ARMED;
            idx_d   = idx_q + 3'd1;
          end
        end
        FINISH: if (x_pos >= finish_x) state_d = DONE;
        DEAD: if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ARMED;
            cnt_d   = '0;
            resp_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      open_q  <= '0;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      open_q  <= open_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    trap_opening = '0;
    for (int i = 0; i < NUM_TRAPS; i++)
      trap_opening[i] = (state_q == OPENING) && (idx_q == 3'(i));
  end

  assign state     = state_q;
  assign trap_idx  = idx_q;
  assign trap_open = open_q;
  assign done      = (state_q == DONE);
  assign respawn   = resp_q;

`ifdef LEVEL_DEATH_COUNT_EN
  logic [DEATH_CNT_W-1:0] dc_q, dc_d;

  always_comb begin
    dc_d = dc_q;
    if (live && death && (dc_q != '1)) dc_d = dc_q + 1'b1;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) dc_q <= '0;
    else       dc_q <= dc_d;
  end

  assign death_count = dc_q;
`endif

endmodule

// File: tb/tb_level_trap_seq.sv
// Bench for level_trap_seq: directed table, corner sequences and random run vs. a rule model.
module tb_level_trap_seq;

  localparam int NT = 3, XW = 10, OW = 6, ST = 2, OD = 8, RT = 4;

  logic            Clk = 1'b0;
  logic            reset, tick, start, death;
  logic [XW-1:0]   x_pos, finish_x;
  logic [NT*XW-1:0] trig_x;
  logic [2:0]      state, trap_idx;
  logic [NT-1:0]   trap_opening, trap_open;
  logic [OW-1:0]   trap_offset;
  logic            done, respawn;
`ifdef LEVEL_DEATH_COUNT_EN
  logic [7:0]      death_count;
`endif

  int n_vec = 0, n_err = 0;
  int m_st, m_idx, m_open, m_off, m_cnt, m_resp, m_dc;
  int trig [NT] = '{100, 200, 300};

  always #5 Clk = ~Clk;

  level_trap_seq #(
    .NUM_TRAPS(NT), .X_WIDTH(XW), .OFS_WIDTH(OW),
    .STEP(ST), .OPEN_DIST(OD), .RESPAWN_TICKS(RT)
  ) dut (
    .Clk(Clk), .reset(reset), .tick(tick), .start(start), .death(death),
    .x_pos(x_pos), .trig_x(trig_x), .finish_x(finish_x),
    .state(state), .trap_idx(trap_idx), .trap_opening(trap_opening),
    .trap_open(trap_open), .trap_offset(trap_offset), .done(done),
    .respawn(respawn)
`ifdef LEVEL_DEATH_COUNT_EN
    , .death_count(death_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_open = 0; m_off = 0; m_cnt = 0; m_resp = 0; m_dc = 0;
  endtask

  // Spec rules, evaluated on the inputs present at a clock edge.
  task automatic model_edge();
    m_resp = 0;
    if ((m_st == 1 || m_st == 2 || m_st == 3) && death) begin
      m_st = 4; m_idx = 0; m_open = 0; m_off = 0; m_cnt = 0;
      if (m_dc < 255) m_dc++;
    end else begin
      case (m_st)
        0, 5: if (start) begin m_st = 1; m_idx = 0; m_open = 0; m_off = 0; end
        1: if (int'(x_pos) > trig[m_idx]) begin m_st = 2; m_off = 0; end
        2: if (tick) begin
          m_off = (m_off + ST > OD) ? OD : m_off + ST;
          if (m_off == OD) begin
            m_open |= (1 << m_idx);
            if (m_idx == NT - 1) m_st = 3;
            else begin m_st = 1; m_idx++; end
          end
        end
        3: if (x_pos >= finish_x) m_st = 5;
        4: if (tick) begin
          m_cnt++;
          if (m_cnt == RT) begin m_st = 1; m_cnt = 0; m_resp = 1; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), m_st);
    chk("trap_idx", 32'(trap_idx), m_idx);
    chk("trap_opening", 32'(trap_opening), (m_st == 2) ? (1 << m_idx) : 0);
    chk("trap_open", 32'(trap_open), m_open);
    chk("trap_offset", 32'(trap_offset), m_off);
    chk("done", 32'(done), (m_st == 5) ? 1 : 0);
    chk("respawn", 32'(respawn), m_resp);
`ifdef LEVEL_DEATH_COUNT_EN
    chk("death_count", 32'(death_count), m_dc);
`endif
  endtask

  task automatic cyc();
    @(posedge Clk);
    if (reset) model_reset(); else model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; death = 0; tick = 0; x_pos = 0;
    cyc();
    reset = 1'b0;
  endtask

  typedef struct {
    bit st, dth, tk;
    int x;
    int e_state, e_idx, e_open, e_off, e_resp;
  } vec_t;

  vec_t tbl [18];
  int   order[$];
  int   tks [NT];
  int   done_x, prev_x, budget;
  logic [NT-1:0] prev_opening;

  initial begin
    // st dth tk x | state idx open off resp (off -1 = not checked here)
    tbl[0]  = '{1, 0, 0,   0, 1, 0, 0,  0, 0};
    tbl[1]  = '{0, 0, 0, 100, 1, 0, 0,  0, 0};
    tbl[2]  = '{0, 0, 1, 100, 1, 0, 0,  0, 0};
    tbl[3]  = '{0, 0, 0, 101, 2, 0, 0,  0, 0};
    tbl[4]  = '{0, 0, 1, 101, 2, 0, 0,  2, 0};
    tbl[5]  = '{0, 0, 1, 101, 2, 0, 0,  4, 0};
    tbl[6]  = '{0, 0, 0, 101, 2, 0, 0,  4, 0};
    tbl[7]  = '{0, 0, 1, 101, 2, 0, 0,  6, 0};
    tbl[8]  = '{0, 0, 1, 101, 1, 1, 1, -1, 0};
    tbl[9]  = '{0, 0, 0, 201, 2, 1, 1,  0, 0};
    tbl[10] = '{0, 0, 1, 201, 2, 1, 1,  2, 0};
    tbl[11] = '{0, 0, 1, 201, 2, 1, 1,  4, 0};
    tbl[12] = '{0, 1, 0,   0, 4, 0, 0,  0, 0};
    tbl[13] = '{0, 0, 1,   0, 4, 0, 0,  0, 0};
    tbl[14] = '{0, 1, 1,   0, 4, 0, 0,  0, 0};
    tbl[15] = '{0, 0, 1,   0, 4, 0, 0,  0, 0};
    tbl[16] = '{0, 0, 1,   0, 1, 0, 0,  0, 1};
    tbl[17] = '{0, 0, 0,   0, 1, 0, 0,  0, 0};

    trig_x   = {10'd300, 10'd200, 10'd100};
    finish_x = 10'd350;
    model_reset();
    do_reset();

    // Trigger boundary, death mid-open, ignored death in DEAD, respawn.
    foreach (tbl[i]) begin
      start = tbl[i].st; death = tbl[i].dth; tick = tbl[i].tk; x_pos = XW'(tbl[i].x);
      cyc();
      chk($sformatf("tbl%0d_state", i), 32'(state), tbl[i].e_state);
      chk($sformatf("tbl%0d_idx", i), 32'(trap_idx), tbl[i].e_idx);
      chk($sformatf("tbl%0d_open", i), 32'(trap_open), tbl[i].e_open);
      if (tbl[i].e_off >= 0) chk($sformatf("tbl%0d_off", i), 32'(trap_offset), tbl[i].e_off);
      chk($sformatf("tbl%0d_resp", i), 32'(respawn), tbl[i].e_resp);
    end
    start = 0; death = 0; tick = 0;

    // Full run: x sweeps 0..400, tick every other Clk.
    do_reset();
    start = 1; cyc(); start = 0;
    order.delete(); foreach (tks[k]) tks[k] = 0;
    done_x = -1; prev_x = 0; prev_opening = '0;
    for (int x = 0; x <= 400; x++) begin
      x_pos = XW'(x); tick = x[0];
      #1;
      if (state == 3'd2 && tick) tks[trap_idx]++;
      cyc();
      if (trap_opening != 0 && prev_opening == 0) order.push_back(int'(trap_idx));
      prev_opening = trap_opening;
      if (done && done_x < 0) done_x = x;
    end
    chk("run_n_opens", order.size(), 3);
    for (int k = 0; k < NT; k++) begin
      chk($sformatf("run_order%0d", k), (k < order.size()) ? order[k] : -1, k);
      chk($sformatf("run_ticks%0d", k), tks[k], 4);
    end
    chk("run_open_final", 32'(trap_open), 7);
    chk("run_done_x", done_x, 350);

    // Death on the same Clk as trap 2's final opening tick.
    do_reset();
    start = 1; cyc(); start = 0;
    x_pos = 10'd400; tick = 1;
    budget = 200;
    while (!(state == 3'd2 && trap_idx == 3'd2 && trap_offset == 6) && budget > 0) begin
      cyc(); budget--;
    end
    chk("sim_reach_budget", (budget > 0) ? 1 : 0, 1);
    death = 1; cyc(); death = 0; tick = 0; x_pos = 0;
    chk("sim_state", 32'(state), 4);
    chk("sim_open2", 32'(trap_open[2]), 0);

    // Reset after 2 DEAD ticks: immediate clear, no respawn afterwards.
    tick = 1; cyc(); cyc();
    tick = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_state", 32'(state), 0);
    chk("rst_zero", 32'({trap_idx, trap_open, trap_opening, trap_offset, done, respawn}), 0);
    cyc();
    reset = 1'b0; tick = 1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rst_no_respawn", 32'(respawn), 0);
    end
    tick = 0;

`ifdef LEVEL_DEATH_COUNT_EN
    // Three counted deaths, then one ignored while in DONE.
    do_reset();
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 3; k++) begin
      death = 1; cyc(); death = 0;
      tick = 1; repeat (RT) cyc(); tick = 0;
    end
    x_pos = 10'd400; tick = 1; budget = 200;
    while (!done && budget > 0) begin cyc(); budget--; end
    chk("dc_done_budget", (budget > 0) ? 1 : 0, 1);
    death = 1; cyc(); death = 0; cyc();
    chk("dc_final", 32'(death_count), 3);
    tick = 0;
`endif

    // Random run against the model.
    do_reset();
    prev_x = 0;
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 19) == 0);
      death = ($urandom_range(0, 39) == 0);
      tick  = $urandom_range(0, 1);
      prev_x = prev_x + $urandom_range(0, 3);
      if (prev_x > 420 || $urandom_range(0, 199) == 0) prev_x = $urandom_range(0, 120);
      x_pos = XW'(prev_x);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/level_trap_seq.md
LEVEL_TRAP_SEQ -- requirements
Module: level_trap_seq

Interface
REQ-001 The block SHALL have parameter NUM_TRAPS, default 3, giving the number of sequential traps in the level (1..8).
REQ-002 The block SHALL have parameter X_WIDTH, default 10, giving the width of player x coordinates.
REQ-003 The block SHALL have parameter OFS_WIDTH, default 6, giving the width of the trap animation offset.
REQ-004 The block SHALL have parameter STEP, default 2, giving the offset increment per game tick.
REQ-005 The block SHALL have parameter OPEN_DIST, default 32, giving the fully-open offset; it must be at least STEP and at most 2^OFS_WIDTH-1.
REQ-006 The block SHALL have parameter RESPAWN_TICKS, default 30, giving the game ticks spent in DEAD (at least 1).
REQ-007 The block SHALL have these ports, listed as name, direction, width, meaning:
- Clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- tick, in, 1, one-Clk game-tick strobe.
- start, in, 1, begin level.
- death, in, 1, player died.
- x_pos, in, X_WIDTH, player x position.
- trig_x, in, NUM_TRAPS*X_WIDTH, trigger x for trap i in slice i.
- finish_x, in, X_WIDTH, goal x position.
- state, out, 3, current state encoding.
- trap_idx, out, 3, index of the current trap.
- trap_opening, out, NUM_TRAPS, one-hot of the trap currently animating.
- trap_open, out, NUM_TRAPS, traps fully open.
- trap_offset, out, OFS_WIDTH, animation offset of the current trap.
- done, out, 1, level complete.
- respawn, out, 1, one-Clk pulse on leaving DEAD.

Function
REQ-008 The state machine SHALL have exactly these states: IDLE, ARMED, OPENING, FINISH, DEAD, DONE.
REQ-009 In IDLE, when start=1 the block SHALL go to ARMED with trap_idx=0 on the next Clk.
REQ-010 In ARMED, when x_pos > trig_x[trap_idx] (unsigned, strictly greater) the block SHALL go to OPENING with trap_offset=0; tick is not required for this transition.
REQ-011 In OPENING, on each tick the block SHALL set trap_offset to the lesser of trap_offset+STEP and OPEN_DIST; with no tick, trap_offset holds.
REQ-012 In OPENING, on the tick where the new offset equals OPEN_DIST, the block SHALL in that same Clk:
- set trap_open[trap_idx];
- clear trap_opening;
- go to ARMED with trap_idx+1, or to FINISH if trap_idx = NUM_TRAPS-1.
REQ-013 trap_opening SHALL equal one-hot(trap_idx) only while in OPENING and SHALL be zero otherwise.
REQ-014 In FINISH, when x_pos >= finish_x the block SHALL go to DONE.
REQ-015 In DONE, done SHALL be 1 and the block SHALL remain in DONE until start=1, which returns it to ARMED with all trap state cleared.
REQ-016 In ARMED, OPENING or FINISH, death=1 SHALL have priority over every other same-cycle event and SHALL, on the next Clk:
- put the block in DEAD;
- clear trap_open, trap_opening and trap_offset;
- set trap_idx to 0.
REQ-017 DEAD SHALL count RESPAWN_TICKS ticks and then go to ARMED while pulsing respawn for one Clk.
REQ-018 death asserted while in DEAD, IDLE or DONE SHALL be ignored and SHALL NOT restart the DEAD count.
REQ-019 The offset arithmetic SHALL be performed at OFS_WIDTH+1 bits so it never wraps.

Reset
REQ-020 reset=1 SHALL immediately, without waiting for a Clk edge, force:
- state to IDLE;
- trap_idx, trap_open, trap_opening and trap_offset to 0;
- done and respawn to 0;
- the DEAD counter to 0.
REQ-021 Reset asserted mid-OPENING or mid-DEAD SHALL abandon the operation with no residual state.

Configuration
REQ-022 When LEVEL_DEATH_COUNT_EN is defined, the block SHALL add an output death_count, 8 bits wide, that:
- increments on each IDLE/DONE-excluded entry into DEAD;
- saturates at 255;
- clears only on reset.
REQ-023 When LEVEL_DEATH_COUNT_EN is undefined, the death_count port and its logic SHALL be absent.

Structure
REQ-024 The state encodings SHALL be defined in shared package level_pkg as: IDLE=0, ARMED=1, OPENING=2, FINISH=3, DEAD=4, DONE=5.
REQ-025 The state type SHALL also be defined in level_pkg.
REQ-026 The offset stepping and saturation SHALL be implemented in sub-module trap_anim_ctr, with inputs clear, en and tick and outputs offset and at_max.

Verification
All scenarios use parameters NUM_TRAPS=3, STEP=2, OPEN_DIST=8 and RESPAWN_TICKS=4.
REQ-027 The bench SHALL cover a full run:
- stimulus: start; trig_x={300,200,100}; x sweeps 0 to 400; finish_x=350.
- response: traps open in order 0,1,2; each opening takes 4 ticks; trap_open ends at 3'b111; done=1 at x=350.
REQ-028 The bench SHALL cover the trigger boundary:
- stimulus: x_pos=100 with trig_x[0]=100, then x_pos=101.
- response: the block stays ARMED at 100 and enters OPENING on the Clk after 101.
REQ-029 The bench SHALL cover a death mid-open:
- stimulus: death at trap_offset=4 of trap 1.
- response: the next Clk shows DEAD, trap_open=0 and trap_offset=0; after 4 ticks respawn pulses and the state is ARMED with trap_idx=0.
REQ-030 The bench SHALL cover simultaneous events:
- stimulus: death on the same Clk as the final opening tick of trap 2.
- response: the block enters DEAD and trap_open[2] stays 0.
REQ-031 The bench SHALL cover reset mid-DEAD:
- stimulus: reset after 2 DEAD ticks.
- response: all outputs are 0 and the state is IDLE asynchronously; no respawn pulse follows.
REQ-032 The bench SHALL cover death counting with LEVEL_DEATH_COUNT_EN defined:
- stimulus: 3 deaths, then a death while in DONE.
- response: death_count=3.
